// File: rtl/tdc_scan_pkg.sv
// tdc_scan_pkg: shared state encoding, tap-address width and scan defaults
package tdc_scan_pkg;
  localparam int TAP_W          = 5;
  localparam int DEF_LAST_ADDR  = 23;
  localparam int DEF_SETTLE_CYC = 2;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_DWELL  = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
endpackage

// File: rtl/tdc_hit_cnt.sv
// tdc_hit_cnt: saturating hit counter with synchronous clear and enable
module tdc_hit_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  // clear wins over enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
endmodule

// File: rtl/tdc_tap_scan_ctrl.sv
// tdc_tap_scan_ctrl: steps the tap decoder address and reports per-tap hit counts
module tdc_tap_scan_ctrl
  import tdc_scan_pkg::*;
#(
  parameter int LAST_ADDR  = DEF_LAST_ADDR,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DWELL_W    = 16,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic               hit,
  output logic [TAP_W-1:0]   addr,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TAP_W-1:0]   res_addr,
  output logic [CNT_W-1:0]   res_count
);
  localparam logic [DWELL_W-1:0] SETTLE_M1 = DWELL_W'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0]   LAST      = TAP_W'(LAST_ADDR);
  logic [2:0]         state;
  logic [DWELL_W-1:0] tmr;
  logic [DWELL_W-1:0] dwell_m1;
  // every output is a decode of registered state, so no input reaches an output combinationally
  assign busy      = state != ST_IDLE;
  assign sel_en    = state == ST_SETTLE || state == ST_DWELL || state == ST_REPORT;
  assign done      = state == ST_DONE;
  assign res_valid = state == ST_REPORT;
  assign res_addr  = addr;
  // scan sequencer: abort overrides everything outside IDLE; one timer serves settle and dwell
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      tmr      <= '0;
      dwell_m1 <= '0;
    end else if (state != ST_IDLE && abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            dwell_m1 <= dwell_len == '0 ? '0 : dwell_len - DWELL_W'(1);
            addr     <= '0;
            tmr      <= '0;
            state    <= ST_SETTLE;
          end
        ST_SETTLE: begin
          tmr   <= tmr == SETTLE_M1 ? '0 : tmr + DWELL_W'(1);
          state <= tmr == SETTLE_M1 ? ST_DWELL : ST_SETTLE;
        end
        ST_DWELL: begin
          tmr   <= tmr == dwell_m1 ? '0 : tmr + DWELL_W'(1);
          state <= tmr == dwell_m1 ? ST_REPORT : ST_DWELL;
        end
        ST_REPORT:
          if (res_ready) begin
            addr  <= addr == LAST ? addr : addr + TAP_W'(1);
            state <= addr == LAST ? ST_DONE : ST_SETTLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  tdc_hit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_SETTLE),
    .en   (state == ST_DWELL && hit),
    .count(res_count)
  );
endmodule

// File: tb/tb_tdc_tap_scan_ctrl.sv
// tb_tdc_tap_scan_ctrl: directed bench for the tap scan sequencer
module tb_tdc_tap_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort, hit, res_ready;
  logic [15:0] dwell_len;
  logic [4:0]  addr, res_addr, addr4, res_addr4;
  logic        sel_en, busy, done, res_valid;
  logic        sel_en4, busy4, done4, res_valid4;
  logic [15:0] res_count;
  logic [3:0]  res_count4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tdc_tap_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell_len(dwell_len), .hit(hit),
    .addr(addr), .sel_en(sel_en), .busy(busy), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_addr(res_addr), .res_count(res_count)
  );
  tdc_tap_scan_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell_len(dwell_len), .hit(hit),
    .addr(addr4), .sel_en(sel_en4), .busy(busy4), .done(done4), .res_valid(res_valid4),
    .res_ready(res_ready), .res_addr(res_addr4), .res_count(res_count4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic [15:0] d);
    @(negedge clk);
    start = 1'b1;
    dwell_len = d;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic scan(input int exp_cnt, input int exp_sat, input int exp_done);
    int n = 0;
    int c = 1;
    bit seen = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_addr", addr, 0);
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (res_valid && res_ready) begin
        chk("res_addr", res_addr, n);
        chk("res_count", res_count, exp_cnt);
        chk("res_count_w4", res_count4, exp_sat);
        n++;
      end
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", c, exp_done);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    chk("done_seen", seen, 1);
    chk("n_results", n, 24);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sel_en", sel_en, 0);
    chk("idle_addr", addr, 23);
  endtask
  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hit = 1'b0; res_ready = 1'b1; dwell_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_en", sel_en, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    rst = 1'b0;
    hit = 1'b1;
    go(16'd4);
    scan(4, 4, 169);
    go(16'd20);
    scan(20, 15, 553);
    go(16'd0);
    scan(1, 1, 97);
    go(16'd4);
    for (int i = 0; i < 100 && !(res_valid && res_addr == 5'd3); i++) @(negedge clk);
    chk("bp_reach", res_valid && res_addr == 5'd3, 1);
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_res_addr", res_addr, 3);
      chk("bp_res_count", res_count, 4);
      chk("bp_addr", addr, 3);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_addr", addr, 4);
    chk("bp_next_valid", res_valid, 0);
    chk("bp_next_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("bp_abort_busy", busy, 0);
    go(16'd4);
    repeat (38) @(negedge clk);
    chk("ab_addr", addr, 5);
    chk("ab_sel_en", sel_en, 1);
    chk("ab_in_dwell", res_valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_valid", res_valid, 0);
    chk("ab_sel_en_low", sel_en, 0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      dn += int'(done);
      @(negedge clk);
    end
    chk("ab_no_done", dn, 0);
    go(16'd4);
    chk("restart_busy", busy, 1);
    chk("restart_addr", addr, 0);
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    chk("rs_valid", res_valid, 1);
    chk("rs_count", res_count, 4);
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_valid_low", res_valid, 0);
    chk("rs_count_low", res_count, 0);
    chk("rs_sel_en", sel_en, 0);
    chk("rs_addr", addr, 0);
    chk("rs_res_addr", res_addr, 0);
    chk("rs_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
